multicycle_control: RTL and testbench

//  Main control FSM of the multicycle MIPS datapath, directly upstream of ULAControl.

---
 rtl/multicycle_control.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic [1:0]       PCSource,
  output logic [1:0]       OpALU,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10
  } state_e;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire_s;

  // State, illegal-opcode pulse and retired-instruction counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      count_q   <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  // Next-state logic; retire_s marks the last cycle of a completed instruction.
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    retire_s  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_R:         state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      state_d = S_MEM_READ;
        else if (opcode == OP_SW) state_d = S_MEM_WRITE;
        else                      state_d = S_FETCH;
      end
      S_MEM_READ: begin
        if (mem_ready) state_d = S_MEM_WB;
        else           state_d = S_MEM_READ;
      end
      S_MEM_WB: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end else begin
          state_d  = S_MEM_WRITE;
        end
      end
      S_EXECUTE: state_d = S_R_WB;
      S_R_WB, S_BRANCH, S_JUMP: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    if (retire_s) count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    else          count_d = count_q;
  end

  // Moore output decode; only the FETCH write enables also look at mem_ready.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    OpALU       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE:   ALUSrcB = 2'b11;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        OpALU   = 2'b10;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        OpALU       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: PCWrite = 1'b0;
    endcase
  end

  assign state       = state_q;
  assign illegal_op  = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a per-cycle vector table fed
// through a scoreboard queue, plus a reset-during-MEM_READ / counter-wrap sequence.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;

  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0]  PCSource, OpALU, ALUSrcB;
  logic        ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [3:0]  state;
  logic [15:0] instr_count;

  logic        PCWrite2, PCWriteCond2, IorD2, MemRead2, MemWrite2, MemtoReg2, IRWrite2;
  logic [1:0]  PCSource2, OpALU2, ALUSrcB2;
  logic        ALUSrcA2, RegWrite2, RegDst2, illegal_op2;
  logic [3:0]  state2;
  logic [1:0]  instr_count2;

  multicycle_control #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .PCSource(PCSource),
    .OpALU(OpALU), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .state(state), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  multicycle_control #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite2), .PCWriteCond(PCWriteCond2), .IorD(IorD2), .MemRead(MemRead2),
    .MemWrite(MemWrite2), .MemtoReg(MemtoReg2), .IRWrite(IRWrite2), .PCSource(PCSource2),
    .OpALU(OpALU2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .RegWrite(RegWrite2),
    .RegDst(RegDst2), .state(state2), .illegal_op(illegal_op2), .instr_count(instr_count2)
  );

  logic [15:0] ctl_a, ctl2_a;
  assign ctl_a  = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                   PCSource, OpALU, ALUSrcA, ALUSrcB, RegWrite, RegDst};
  assign ctl2_a = {PCWrite2, PCWriteCond2, IorD2, MemRead2, MemWrite2, MemtoReg2, IRWrite2,
                   PCSource2, OpALU2, ALUSrcA2, ALUSrcB2, RegWrite2, RegDst2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        ill;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Control word packed in the same order as ctl_a.
  function automatic logic [15:0] ctl(input logic pcw, input logic pcwc, input logic iord,
                                      input logic mrd, input logic mwr, input logic m2r,
                                      input logic irw, input logic [1:0] pcs,
                                      input logic [1:0] op, input logic asa,
                                      input logic [1:0] asb, input logic rw, input logic rd);
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, pcs, op, asa, asb, rw, rd};
  endfunction

  function automatic vec_t mk(input logic [5:0] op, input logic mr, input logic [3:0] st,
                              input logic [15:0] c, input logic ill, input logic [15:0] cnt);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st; v.ctl = c; v.ill = ill; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, JP = 6'b000010, BAD = 6'b111111;

  logic [15:0] c_idle, c_f1, c_f0, c_dec, c_ma, c_mrd, c_mwb, c_mwr, c_exe, c_rwb, c_br, c_j;

  initial begin
    //                pcw   pcwc  iord  mrd   mwr   m2r   irw   pcs    op     asa   asb    rw    rd
    c_idle = 16'h0000;
    c_f1  = ctl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0);
    c_f0  = ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0);
    c_dec = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0);
    c_ma  = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0);
    c_mrd = ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
    c_mwb = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0);
    c_mwr = ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
    c_exe = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0);
    c_rwb = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1);
    c_br  = ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0);
    c_j   = ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);

    // One row per clock cycle: inputs for that cycle and the expected Moore outputs.
    // R-type with mem_ready low outside memory states (ignored there)
    tbl.push_back(mk(R,   1'b1, 4'd0,  c_idle, 1'b0, 16'd0));
    tbl.push_back(mk(R,   1'b1, 4'd1,  c_f1,   1'b0, 16'd0));
    tbl.push_back(mk(R,   1'b0, 4'd2,  c_dec,  1'b0, 16'd0));
    tbl.push_back(mk(R,   1'b0, 4'd7,  c_exe,  1'b0, 16'd0));
    tbl.push_back(mk(R,   1'b0, 4'd8,  c_rwb,  1'b0, 16'd0));
    // lw with three wait cycles in MEM_READ
    tbl.push_back(mk(LW,  1'b1, 4'd1,  c_f1,   1'b0, 16'd1));
    tbl.push_back(mk(LW,  1'b1, 4'd2,  c_dec,  1'b0, 16'd1));
    tbl.push_back(mk(LW,  1'b1, 4'd3,  c_ma,   1'b0, 16'd1));
    tbl.push_back(mk(LW,  1'b0, 4'd4,  c_mrd,  1'b0, 16'd1));
    tbl.push_back(mk(LW,  1'b0, 4'd4,  c_mrd,  1'b0, 16'd1));
    tbl.push_back(mk(LW,  1'b0, 4'd4,  c_mrd,  1'b0, 16'd1));
    tbl.push_back(mk(LW,  1'b1, 4'd4,  c_mrd,  1'b0, 16'd1));
    tbl.push_back(mk(LW,  1'b0, 4'd5,  c_mwb,  1'b0, 16'd1));
    // fetch stall, then sw with one MEM_WRITE wait cycle
    tbl.push_back(mk(SW,  1'b0, 4'd1,  c_f0,   1'b0, 16'd2));
    tbl.push_back(mk(SW,  1'b1, 4'd1,  c_f1,   1'b0, 16'd2));
    tbl.push_back(mk(SW,  1'b0, 4'd2,  c_dec,  1'b0, 16'd2));
    tbl.push_back(mk(SW,  1'b0, 4'd3,  c_ma,   1'b0, 16'd2));
    tbl.push_back(mk(SW,  1'b0, 4'd6,  c_mwr,  1'b0, 16'd2));
    tbl.push_back(mk(SW,  1'b1, 4'd6,  c_mwr,  1'b0, 16'd2));
    // beq, then j
    tbl.push_back(mk(BQ,  1'b1, 4'd1,  c_f1,   1'b0, 16'd3));
    tbl.push_back(mk(BQ,  1'b1, 4'd2,  c_dec,  1'b0, 16'd3));
    tbl.push_back(mk(BQ,  1'b1, 4'd9,  c_br,   1'b0, 16'd3));
    tbl.push_back(mk(JP,  1'b1, 4'd1,  c_f1,   1'b0, 16'd4));
    tbl.push_back(mk(JP,  1'b1, 4'd2,  c_dec,  1'b0, 16'd4));
    tbl.push_back(mk(JP,  1'b1, 4'd10, c_j,    1'b0, 16'd4));
    // illegal opcode: one-cycle pulse in the following FETCH, not counted
    tbl.push_back(mk(BAD, 1'b1, 4'd1,  c_f1,   1'b0, 16'd5));
    tbl.push_back(mk(BAD, 1'b1, 4'd2,  c_dec,  1'b0, 16'd5));
    tbl.push_back(mk(R,   1'b1, 4'd1,  c_f1,   1'b1, 16'd5));
    tbl.push_back(mk(R,   1'b1, 4'd2,  c_dec,  1'b0, 16'd5));
    tbl.push_back(mk(R,   1'b1, 4'd7,  c_exe,  1'b0, 16'd5));
    tbl.push_back(mk(R,   1'b1, 4'd8,  c_rwb,  1'b0, 16'd5));
    tbl.push_back(mk(LW,  1'b1, 4'd1,  c_f1,   1'b0, 16'd6));

    rst_n = 1'b0; opcode = R; mem_ready = 1'b1;
    #3;
    chk("reset state", {28'd0, state}, 32'd0);
    chk("reset ctl",   {16'd0, ctl_a}, 32'd0);
    chk("reset ill",   {31'd0, illegal_op}, 32'd0);
    chk("reset count", {16'd0, instr_count}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t e;
      opcode    = tbl[i].op;
      mem_ready = tbl[i].mr;
      sb.push_back(tbl[i]);
      #1;
      e = sb.pop_front();
      chk($sformatf("row%0d state", i), {28'd0, state}, {28'd0, e.st});
      chk($sformatf("row%0d ctl", i),   {16'd0, ctl_a}, {16'd0, e.ctl});
      chk($sformatf("row%0d ill", i),   {31'd0, illegal_op}, {31'd0, e.ill});
      chk($sformatf("row%0d count", i), {16'd0, instr_count}, {16'd0, e.cnt});
      chk($sformatf("row%0d count2", i), {30'd0, instr_count2}, {30'd0, e.cnt[1:0]});
      @(negedge clk);
    end

    // lw in flight: DECODE, MEM_ADDR, then stall in MEM_READ and reset mid-cycle
    opcode = LW; mem_ready = 1'b1;
    #1 chk("lw decode", {28'd0, state}, 32'd2);
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #1 chk("in mem_read", {28'd0, state}, 32'd4);
    chk("mem_read ctl", {16'd0, ctl_a}, {16'd0, c_mrd});
    #2 rst_n = 1'b0;
    #1;
    chk("midreset state", {28'd0, state}, 32'd0);
    chk("midreset ctl",   {16'd0, ctl_a}, 32'd0);
    chk("midreset count", {16'd0, instr_count}, 32'd0);
    chk("midreset ctl2",  {16'd0, ctl2_a}, 32'd0);

    // five jumps after reset: 1 cycle IDLE + 5 x 3 cycles
    @(negedge clk);
    opcode = JP; mem_ready = 1'b1; rst_n = 1'b1;
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("wrap state",  {28'd0, state}, 32'd1);
    chk("wrap count",  {16'd0, instr_count}, 32'd5);
    chk("wrap count2", {30'd0, instr_count2}, 32'd1);
    chk("wrap ill",    {31'd0, illegal_op}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
